// File: rtl/triangle_fetch.sv
// ----------------------------------------------------------------------------
// triangle_fetch
//
// Upstream feeder for the rasterizer. A new_frame pulse starts a walk over a
// triangle list held in an external synchronous vertex ROM. The ROM holds one
// vertex per word and three words per triangle, so triangle n is at 3n..3n+2.
// Each triangle is assembled from its three words and clamped to the screen.
// It is then offered on vert1/2/3 under a valid/ready handshake.
// obj_done_out marks the last triangle of the list.
//
// Ports
//   clk_in         single system clock
//   rst_in         asynchronous, active-low reset
//   new_frame_in   1-cycle pulse: start a traversal at triangle 0
//   rom_addr_out   vertex ROM address (registered, holds outside FETCH)
//   rom_data_in    vertex word {x[26:18], y[17:9], z[8:0]}, ROM_LATENCY late
//   vert1_out      triangle vertex 1: [2]=x, [1]=y, [0]=z
//   vert2_out      triangle vertex 2, same layout
//   vert3_out      triangle vertex 3, same layout
//   valid_tri_out  vert*_out carry a triangle for the rasterizer
//   ready_in       rasterizer can accept a triangle
//   obj_done_out   high with valid_tri_out on the final triangle of the list
//   busy_out       high whenever the FSM is not idle
//   tri_idx_out    index of the triangle being fetched or presented
// ----------------------------------------------------------------------------
module triangle_fetch #(
   parameter int NUM_TRIS    = 12,
   parameter int ROM_LATENCY = 2,
   parameter int WIDTH       = 360,
   parameter int HEIGHT      = 360,
   parameter int ADDR_W      = $clog2(3 * NUM_TRIS),
   parameter int IDX_W       = $clog2(NUM_TRIS + 1)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              new_frame_in,
   output logic [ADDR_W-1:0] rom_addr_out,
   input  logic [26:0]       rom_data_in,
   output logic [2:0][8:0]   vert1_out,
   output logic [2:0][8:0]   vert2_out,
   output logic [2:0][8:0]   vert3_out,
   output logic              valid_tri_out,
   input  logic              ready_in,
   output logic              obj_done_out,
   output logic              busy_out,
   output logic [IDX_W-1:0]  tri_idx_out
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      PRESENT
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRIS - 1);

   // First ROM word of a triangle.
   function automatic logic [ADDR_W-1:0] tri_base(input logic [IDX_W-1:0] idx);
      return ADDR_W'(3 * int'(idx));
   endfunction

   // Saturate an unsigned coordinate to the last pixel of its axis.
   function automatic logic [8:0] clamp(input logic [8:0] v, input int lim);
      return (int'(v) >= lim) ? 9'(lim - 1) : v;
   endfunction

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              pending_q, pending_d;
   logic              req;
   logic              transfer;

   // ROM return tracking: one tag per outstanding request. A tag carries the
   // word slot (0..2) down a ROM_LATENCY-deep pipe. The word sits on
   // rom_data_in while its tag is in the last stage.
   logic              req_v_q    [ROM_LATENCY];
   logic [1:0]        req_slot_q [ROM_LATENCY];
   logic              cap_v;
   logic [1:0]        cap_slot;

   logic [2:0][8:0]   vert_q [3];

   assign cap_v    = req_v_q[ROM_LATENCY-1];
   assign cap_slot = req_slot_q[ROM_LATENCY-1];
   assign transfer = (state_q == PRESENT) && ready_in;

   // -------------------------------------------------------------------------
   // Next-state and datapath-control logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d   = state_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      req       = 1'b0;

      // A frame request while busy is remembered. Repeated pulses collapse
      // into one.
      if (new_frame_in && (state_q != IDLE)) pending_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (new_frame_in || pending_q) begin
               pending_d = 1'b0;
               idx_d     = '0;
               addr_d    = '0;
               cnt_d     = '0;
               state_d   = FETCH;
            end
         end

         FETCH: begin
            // The address register already holds the word for this cycle.
            // Advance it for the next word, but hold at 3n+2 after the last.
            req = 1'b1;
            if (cnt_q == 2'd2) begin
               cnt_d   = '0;
               state_d = DRAIN;
            end else begin
               cnt_d  = cnt_q + 2'd1;
               addr_d = addr_q + ADDR_W'(1);
            end
         end

         DRAIN: begin
            if (cap_v && (cap_slot == 2'd2)) state_d = PRESENT;
         end

         PRESENT: begin
            if (transfer) begin
               cnt_d = '0;
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  // A pulse coinciding with the final transfer restarts the
                  // walk immediately, as does one remembered earlier.
                  if (pending_q || new_frame_in) begin
                     pending_d = 1'b0;
                     addr_d    = '0;
                     state_d   = FETCH;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  addr_d  = tri_base(idx_q + IDX_W'(1));
                  state_d = FETCH;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Control registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so all
         // registers update together from pre-edge values.
         state_q   <= state_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
      end
   end

   // -------------------------------------------------------------------------
   // ROM request tag pipeline. Reset clears it, which drops any fetch in flight.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < ROM_LATENCY; i++) begin
            req_v_q[i]    <= 1'b0;
            req_slot_q[i] <= '0;
         end
      end else begin
         req_v_q[0]    <= req;
         req_slot_q[0] <= cnt_q;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            req_v_q[i]    <= req_v_q[i-1];
            req_slot_q[i] <= req_slot_q[i-1];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Vertex capture with clamping. Captures happen only in FETCH and DRAIN,
   // so the vertices stay stable throughout PRESENT.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         // NOTE: this small register array drives outputs directly, so it is
         // reset. A large storage array would normally be left unreset.
         for (int i = 0; i < 3; i++) vert_q[i] <= '0;
      end else if (cap_v) begin
         unique case (cap_slot)
            2'd0:    vert_q[0] <= {clamp(rom_data_in[26:18], WIDTH),
                                   clamp(rom_data_in[17:9], HEIGHT),
                                   rom_data_in[8:0]};
            2'd1:    vert_q[1] <= {clamp(rom_data_in[26:18], WIDTH),
                                   clamp(rom_data_in[17:9], HEIGHT),
                                   rom_data_in[8:0]};
            default: vert_q[2] <= {clamp(rom_data_in[26:18], WIDTH),
                                   clamp(rom_data_in[17:9], HEIGHT),
                                   rom_data_in[8:0]};
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs. All of them decode registered state, so valid_tri_out never
   // depends combinationally on ready_in.
   // -------------------------------------------------------------------------
   assign rom_addr_out  = addr_q;
   assign vert1_out     = vert_q[0];
   assign vert2_out     = vert_q[1];
   assign vert3_out     = vert_q[2];
   assign valid_tri_out = (state_q == PRESENT);
   assign obj_done_out  = valid_tri_out && (idx_q == LAST_IDX);
   assign busy_out      = (state_q != IDLE);
   assign tri_idx_out   = idx_q;

endmodule

// File: tb/tb_triangle_fetch.sv
// ----------------------------------------------------------------------------
// tb_triangle_fetch
//
// Directed bench for triangle_fetch with a two-triangle list and a 2-cycle ROM
// model. Inputs are driven and outputs sampled on the falling edge. Cycle k is
// the period after rising edge k-1, so a pulse sampled at edge 0 puts the
// design in FETCH during cycle 1.
// ----------------------------------------------------------------------------
module tb_triangle_fetch;

   localparam int NUM_TRIS = 2;
   localparam int ADDR_W   = $clog2(3 * NUM_TRIS);
   localparam int IDX_W    = $clog2(NUM_TRIS + 1);

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic              new_frame_in;
   logic [ADDR_W-1:0] rom_addr_out;
   logic [26:0]       rom_data_in;
   logic [2:0][8:0]   vert1_out, vert2_out, vert3_out;
   logic              valid_tri_out;
   logic              ready_in;
   logic              obj_done_out;
   logic              busy_out;
   logic [IDX_W-1:0]  tri_idx_out;

   int checks = 0;
   int errors = 0;

   // Raw ROM words, including out-of-range x/y values.
   logic [26:0] rom [6];
   logic [26:0] rom_q1;

   // Expected assembled vertices after clamping (WIDTH = HEIGHT = 360).
   localparam logic [26:0] T0V1 = {9'd359, 9'd359, 9'd7};
   localparam logic [26:0] T0V2 = {9'd359, 9'd0,   9'd100};
   localparam logic [26:0] T0V3 = {9'd10,  9'd20,  9'd30};
   localparam logic [26:0] T1V1 = {9'd1,   9'd2,   9'd3};
   localparam logic [26:0] T1V2 = {9'd359, 9'd359, 9'd511};
   localparam logic [26:0] T1V3 = {9'd100, 9'd200, 9'd300};

   triangle_fetch #(
      .NUM_TRIS   (NUM_TRIS),
      .ROM_LATENCY(2),
      .WIDTH      (360),
      .HEIGHT     (360)
   ) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .new_frame_in (new_frame_in),
      .rom_addr_out (rom_addr_out),
      .rom_data_in  (rom_data_in),
      .vert1_out    (vert1_out),
      .vert2_out    (vert2_out),
      .vert3_out    (vert3_out),
      .valid_tri_out(valid_tri_out),
      .ready_in     (ready_in),
      .obj_done_out (obj_done_out),
      .busy_out     (busy_out),
      .tri_idx_out  (tri_idx_out)
   );

   always #5 clk_in = ~clk_in;

   // Synchronous ROM: a BRAM register followed by an output register.
   always @(posedge clk_in) begin
      rom_q1      <= (int'(rom_addr_out) < 6) ? rom[rom_addr_out] : 27'd0;
      rom_data_in <= rom_q1;
   end

   initial begin
      rom[0] = {9'd400, 9'd360, 9'd7};
      rom[1] = {9'd359, 9'd0,   9'd100};
      rom[2] = {9'd10,  9'd20,  9'd30};
      rom[3] = {9'd1,   9'd2,   9'd3};
      rom[4] = {9'd360, 9'd361, 9'd511};
      rom[5] = {9'd100, 9'd200, 9'd300};
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   // Called on a falling edge; returns on the falling edge of cycle 1.
   task automatic pulse_frame();
      new_frame_in = 1'b1;
      @(negedge clk_in);
      new_frame_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_in = 1'b0; new_frame_in = 1'b0; ready_in = 1'b0;
      step(2);
      checks++; if (valid_tri_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid_tri_out); end
      checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_out); end
      checks++; if (obj_done_out !== 1'b0) begin errors++; $display("FAIL reset_obj_done: got %0b expected 0", obj_done_out); end
      checks++; if (rom_addr_out !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rom_addr_out); end
      checks++; if (tri_idx_out !== '0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", tri_idx_out); end
      checks++; if (vert1_out !== 27'd0) begin errors++; $display("FAIL reset_vert1: got %h expected 0", vert1_out); end
      rst_in = 1'b1;
      step(2);
      checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_idle_after_release: got %0b expected 0", busy_out); end
   endtask

   task automatic test_basic();
      ready_in = 1'b1;
      pulse_frame();                                   // cycle 1
      checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL basic_busy_c1: got %0b expected 1", busy_out); end
      checks++; if (rom_addr_out !== 3'd0) begin errors++; $display("FAIL basic_addr_c1: got %0d expected 0", rom_addr_out); end
      step(1);                                         // cycle 2
      checks++; if (rom_addr_out !== 3'd1) begin errors++; $display("FAIL basic_addr_c2: got %0d expected 1", rom_addr_out); end
      step(1);                                         // cycle 3
      checks++; if (rom_addr_out !== 3'd2) begin errors++; $display("FAIL basic_addr_c3: got %0d expected 2", rom_addr_out); end
      step(2);                                         // cycle 5
      checks++; if (valid_tri_out !== 1'b0) begin errors++; $display("FAIL basic_valid_c5: got %0b expected 0", valid_tri_out); end
      step(1);                                         // cycle 6
      checks++; if (valid_tri_out !== 1'b1) begin errors++; $display("FAIL basic_valid_c6: got %0b expected 1", valid_tri_out); end
      checks++; if (obj_done_out !== 1'b0) begin errors++; $display("FAIL basic_obj_done_t0: got %0b expected 0", obj_done_out); end
      checks++; if (vert1_out !== T0V1) begin errors++; $display("FAIL clamp_t0_vert1: got %h expected %h", vert1_out, T0V1); end
      checks++; if (vert2_out !== T0V2) begin errors++; $display("FAIL pass_t0_vert2: got %h expected %h", vert2_out, T0V2); end
      checks++; if (vert3_out !== T0V3) begin errors++; $display("FAIL t0_vert3: got %h expected %h", vert3_out, T0V3); end
      step(1);                                         // cycle 7
      checks++; if (valid_tri_out !== 1'b0) begin errors++; $display("FAIL basic_valid_c7: got %0b expected 0", valid_tri_out); end
      checks++; if (rom_addr_out !== 3'd3) begin errors++; $display("FAIL basic_addr_c7: got %0d expected 3", rom_addr_out); end
      checks++; if (tri_idx_out !== 2'd1) begin errors++; $display("FAIL basic_idx_c7: got %0d expected 1", tri_idx_out); end
      step(4);                                         // cycle 11
      checks++; if (valid_tri_out !== 1'b0) begin errors++; $display("FAIL basic_gap_c11: got %0b expected 0", valid_tri_out); end
      step(1);                                         // cycle 12
      checks++; if (valid_tri_out !== 1'b1) begin errors++; $display("FAIL basic_valid_c12: got %0b expected 1", valid_tri_out); end
      checks++; if (obj_done_out !== 1'b1) begin errors++; $display("FAIL basic_obj_done_t1: got %0b expected 1", obj_done_out); end
      checks++; if (vert1_out !== T1V1) begin errors++; $display("FAIL t1_vert1: got %h expected %h", vert1_out, T1V1); end
      checks++; if (vert2_out !== T1V2) begin errors++; $display("FAIL clamp_t1_vert2: got %h expected %h", vert2_out, T1V2); end
      checks++; if (vert3_out !== T1V3) begin errors++; $display("FAIL t1_vert3: got %h expected %h", vert3_out, T1V3); end
      step(1);                                         // cycle 13
      checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %0b expected 0", busy_out); end
      checks++; if (obj_done_out !== 1'b0) begin errors++; $display("FAIL basic_idle_obj_done: got %0b expected 0", obj_done_out); end
      checks++; if (tri_idx_out !== 2'd0) begin errors++; $display("FAIL basic_idle_idx: got %0d expected 0", tri_idx_out); end
      checks++; if (rom_addr_out !== 3'd5) begin errors++; $display("FAIL basic_addr_hold: got %0d expected 5", rom_addr_out); end
   endtask

   task automatic test_stall();
      ready_in = 1'b0;
      pulse_frame();                                   // cycle 1
      step(5);                                         // cycle 6
      for (int i = 0; i < 10; i++) begin
         checks++; if (valid_tri_out !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d: got %0b expected 1", i, valid_tri_out); end
         checks++; if ({vert1_out, vert2_out, vert3_out} !== {T0V1, T0V2, T0V3}) begin errors++; $display("FAIL stall_verts_%0d: got %h expected %h", i, {vert1_out, vert2_out, vert3_out}, {T0V1, T0V2, T0V3}); end
         step(1);
      end
      ready_in = 1'b1;
      step(1);
      ready_in = 1'b0;
      checks++; if (valid_tri_out !== 1'b0) begin errors++; $display("FAIL stall_drop: got %0b expected 0", valid_tri_out); end
      checks++; if (tri_idx_out !== 2'd1) begin errors++; $display("FAIL stall_one_transfer: got %0d expected 1", tri_idx_out); end
      step(5);
      checks++; if (obj_done_out !== 1'b1) begin errors++; $display("FAIL stall_t1_obj_done: got %0b expected 1", obj_done_out); end
      step(3);
      checks++; if ({valid_tri_out, obj_done_out} !== 2'b11) begin errors++; $display("FAIL stall_t1_hold: got %b expected 11", {valid_tri_out, obj_done_out}); end
      ready_in = 1'b1;
      step(1);
      ready_in = 1'b0;
      checks++; if ({valid_tri_out, obj_done_out, busy_out} !== 3'b000) begin errors++; $display("FAIL stall_end: got %b expected 000", {valid_tri_out, obj_done_out, busy_out}); end
   endtask

   task automatic test_pending();
      ready_in = 1'b1;
      pulse_frame();                                   // cycle 1
      step(1);                                         // cycle 2
      pulse_frame();                                   // cycle 3
      step(4);                                         // cycle 7
      pulse_frame();                                   // cycle 8
      step(4);                                         // cycle 12
      checks++; if (obj_done_out !== 1'b1) begin errors++; $display("FAIL pending_last: got %0b expected 1", obj_done_out); end
      step(1);                                         // cycle 13
      checks++; if ({busy_out, valid_tri_out} !== 2'b10) begin errors++; $display("FAIL pending_restart: got %b expected 10", {busy_out, valid_tri_out}); end
      checks++; if (rom_addr_out !== 3'd0) begin errors++; $display("FAIL pending_addr0: got %0d expected 0", rom_addr_out); end
      step(5);                                         // cycle 18
      checks++; if (vert1_out !== T0V1 || valid_tri_out !== 1'b1) begin errors++; $display("FAIL pending_t0: got %h/%0b expected %h/1", vert1_out, valid_tri_out, T0V1); end
      step(6);                                         // cycle 24
      checks++; if (obj_done_out !== 1'b1) begin errors++; $display("FAIL pending_t1_done: got %0b expected 1", obj_done_out); end
      step(1);
      checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL pending_idle: got %0b expected 0", busy_out); end
      step(10);
      checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL pending_single_extra: got %0b expected 0", busy_out); end
   endtask

   task automatic test_same_cycle();
      ready_in = 1'b1;
      pulse_frame();                                   // cycle 1
      step(11);                                        // cycle 12
      checks++; if (obj_done_out !== 1'b1) begin errors++; $display("FAIL same_last: got %0b expected 1", obj_done_out); end
      new_frame_in = 1'b1;
      step(1);                                         // cycle 13
      new_frame_in = 1'b0;
      checks++; if ({busy_out, valid_tri_out} !== 2'b10) begin errors++; $display("FAIL same_fetch: got %b expected 10", {busy_out, valid_tri_out}); end
      checks++; if (rom_addr_out !== 3'd0) begin errors++; $display("FAIL same_addr0: got %0d expected 0", rom_addr_out); end
      checks++; if (tri_idx_out !== 2'd0) begin errors++; $display("FAIL same_idx0: got %0d expected 0", tri_idx_out); end
      step(5);                                         // cycle 18
      checks++; if (valid_tri_out !== 1'b1) begin errors++; $display("FAIL same_valid: got %0b expected 1", valid_tri_out); end
      step(7);
      checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL same_idle: got %0b expected 0", busy_out); end
   endtask

   task automatic test_reset_drain();
      ready_in = 1'b1;
      pulse_frame();                                   // cycle 1
      step(3);                                         // cycle 4, DRAIN
      checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL rdrain_busy: got %0b expected 1", busy_out); end
      #1 rst_in = 1'b0;
      #1;
      checks++; if ({valid_tri_out, busy_out, obj_done_out} !== 3'b000) begin errors++; $display("FAIL rdrain_async_flags: got %b expected 000", {valid_tri_out, busy_out, obj_done_out}); end
      checks++; if (rom_addr_out !== '0 || tri_idx_out !== '0) begin errors++; $display("FAIL rdrain_async_addr_idx: got %0d/%0d expected 0/0", rom_addr_out, tri_idx_out); end
      checks++; if ({vert1_out, vert2_out, vert3_out} !== 81'd0) begin errors++; $display("FAIL rdrain_async_verts: got %h expected 0", {vert1_out, vert2_out, vert3_out}); end
      @(negedge clk_in);
      rst_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         checks++; if (valid_tri_out !== 1'b0) begin errors++; $display("FAIL rdrain_quiet_%0d: got %0b expected 0", i, valid_tri_out); end
      end
      pulse_frame();
      step(5);
      checks++; if (valid_tri_out !== 1'b1 || vert1_out !== T0V1) begin errors++; $display("FAIL rdrain_recover: got %0b/%h expected 1/%h", valid_tri_out, vert1_out, T0V1); end
      step(7);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_pending();
      test_same_cycle();
      test_reset_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
